// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory port bundle between the IF stage and imem.
// The fetch stage drives address/data/byte-enables and reads back the word.
interface instr_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [3:0]  imem_we;
  logic [31:0] imem_q;

  modport master (
    output imem_addr,
    output imem_data,
    output imem_we,
    input  imem_q
  );

  modport slave (
    input  imem_addr,
    input  imem_data,
    input  imem_we,
    output imem_q
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage: PC, IF/ID latch, stall/flush handling and branch/jump redirects.
// A redirect seen while stalled is parked and applied once the stall drops.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  instr_fetch_stage_if.master imem,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_taken,
  input  logic [31:0] jmp_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN,
    HOLD_REDIR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic [31:0] r_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_valid;
  logic        r_mis;
  logic [31:0] r_cnt;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_nxt;
  logic [31:0] w_pc4;
  logic        w_req;
  logic [31:0] w_raw;
  logic [31:0] w_tgt;
  logic        w_mis;
  logic        w_ld;
  logic        w_bub;
  logic        w_go;
  logic        w_pend;

  assign imem.imem_addr = r_pc;
  assign imem.imem_data = 32'h0;
  assign imem.imem_we   = 4'b0000;

  assign w_pc4 = r_pc + 32'd4;
  assign w_req = br_taken | jmp_taken;
  // Branch is the older instruction, so it wins over a jump.
  assign w_raw = br_taken ? br_target : jmp_target;
  assign w_tgt = {w_raw[31:2], 2'b00};
  assign w_mis = w_req & (|w_raw[1:0]);

  assign w_go   = ~stall & w_req;
  assign w_pend = ~stall & ~w_req & (r_state == HOLD_REDIR);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_pc;
    w_ld        = 1'b0;
    w_bub       = 1'b0;
    unique case (1'b1)
      stall: begin
        if (w_req) begin
          w_state_nxt = HOLD_REDIR;
          w_pend_nxt  = w_tgt;
        end
        w_bub = flush;
      end
      w_go: begin
        w_pc_nxt    = w_tgt;
        w_bub       = 1'b1;
        w_state_nxt = RUN;
      end
      w_pend: begin
        w_pc_nxt    = r_pend_pc;
        w_bub       = 1'b1;
        w_state_nxt = RUN;
      end
      default: begin
        w_pc_nxt = w_pc4;
        w_ld     = ~flush;
        w_bub    = flush;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_pend_pc <= 32'h0;
      r_instr   <= NOP_INSTR;
      r_id_pc   <= 32'h0;
      r_id_pc4  <= 32'h0;
      r_valid   <= 1'b0;
      r_mis     <= 1'b0;
      r_cnt     <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_mis     <= w_mis;
      if (w_ld) begin
        r_instr  <= imem.imem_q;
        r_id_pc  <= r_pc;
        r_id_pc4 <= w_pc4;
        r_valid  <= 1'b1;
        r_cnt    <= r_cnt + 32'd1;
      end else if (w_bub) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign if_id_instr  = r_instr;
  assign if_id_pc     = r_id_pc;
  assign if_id_pc4    = r_id_pc4;
  assign if_id_valid  = r_valid;
  assign misalign_err = r_mis;
  assign fetch_count  = r_cnt;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed plan then random traffic
// compared against a behavioural fetch model with its own instruction memory.
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, br_taken, jmp_taken;
  logic [31:0] br_target, jmp_target;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign_err;

  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc, m_ppc, m_instr, m_ipc, m_ip4, m_cnt;
  bit          m_pv, m_valid, m_mis;

  instr_fetch_stage_if u_if ();

  assign u_if.imem_q = mem[u_if.imem_addr[9:2]];

  instr_fetch_stage u_dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (u_if.master),
    .stall        (stall),
    .flush        (flush),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_taken    (jmp_taken),
    .jmp_target   (jmp_target),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] raw;
    bit          req;
    if (rst) begin
      m_pc = 32'h0; m_ppc = 0; m_pv = 0; m_instr = NOP;
      m_ipc = 0; m_ip4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
      return;
    end
    req   = br_taken || jmp_taken;
    raw   = br_taken ? br_target : jmp_target;
    m_mis = req && (raw % 4 != 0);
    raw   = raw - (raw % 4);
    if (stall) begin
      if (req) begin m_pv = 1; m_ppc = raw; end
      if (flush) begin m_instr = NOP; m_valid = 0; end
    end else if (req || m_pv) begin
      m_pc    = req ? raw : m_ppc;
      m_pv    = 0;
      m_instr = NOP;
      m_valid = 0;
    end else begin
      if (flush) begin
        m_instr = NOP; m_valid = 0;
      end else begin
        m_instr = mem[(m_pc / 4) % 256];
        m_ipc   = m_pc;
        m_ip4   = m_pc + 4;
        m_valid = 1;
        m_cnt   = m_cnt + 1;
      end
      m_pc = m_pc + 4;
    end
  endtask

  task automatic check_all();
    chk("imem_addr", u_if.imem_addr, m_pc);
    chk("imem_data", u_if.imem_data, 32'h0);
    chk("imem_we",   {28'h0, u_if.imem_we}, 32'h0);
    chk("valid",     {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("instr",     if_id_instr, m_instr);
    if (m_valid) begin
      chk("id_pc",  if_id_pc,  m_ipc);
      chk("id_pc4", if_id_pc4, m_ip4);
    end
    chk("misalign", {31'h0, misalign_err}, {31'h0, m_mis});
    chk("count",    fetch_count, m_cnt);
  endtask

  task automatic step(input bit r, input bit s, input bit f,
                      input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    rst = r; stall = s; flush = f;
    br_taken = b; br_target = bt; jmp_taken = j; jmp_target = jt;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    rst = 1; stall = 0; flush = 0;
    br_taken = 0; jmp_taken = 0; br_target = 0; jmp_target = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_cnt4", fetch_count, 32'd4);
    chk("plan_instr4", if_id_instr, 32'd4);

    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("plan_stall_pc", u_if.imem_addr, 32'h8);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_resume", if_id_pc, 32'h8);

    step(0, 0, 0, 1, 32'h88, 1, 32'h40);
    chk("plan_brwin", u_if.imem_addr, 32'h88);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_brpc", if_id_pc, 32'h88);

    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'hA0);
    step(0, 1, 0, 1, 32'hB0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_pend", u_if.imem_addr, 32'hB0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_pendpc", if_id_pc, 32'hB0);

    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h43);
    chk("plan_mis_pc", u_if.imem_addr, 32'h40);
    step(0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 0, 0, 0, 1, 32'h200);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_rst_pend", if_id_pc, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      logic [31:0] bt, jt;
      bt = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'h3FF);
      jt = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'h3FF);
      step($urandom % 60 == 0, $urandom % 4 == 0, $urandom % 10 == 0,
           $urandom % 10 == 0, bt, $urandom % 10 == 0, jt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
